// File: rtl/rom_load_pkg.sv
// rom_load_pkg: shared types and constants for the ioctl download sequencer
package rom_load_pkg;
  typedef enum logic [1:0] {RUN, LOAD, HOLD} state_t;
  localparam logic [7:0] ROM_IDX = 8'd0;
  localparam logic [7:0] MOD_IDX = 8'd1;
  localparam logic [7:0] SW_IDX = 8'd254;
  localparam logic [7:0] SW_RESET_VAL = 8'hFF;
  localparam int unsigned ROM_SIZE_DEF = 65536;
  localparam int unsigned RST_CYCLES_DEF = 256;
endpackage

// File: rtl/edge_det.sv
// edge_det: registered rise/fall detector, edges taken against the one-cycle-old copy
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   d_i       level input
//   rise_o    d_i high now, low last cycle
//   fall_o    d_i low now, high last cycle
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);
  logic d_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) d_q <= 1'b0;
    else d_q <= d_i;
  assign rise_o = d_i & ~d_q;
  assign fall_o = ~d_i & d_q;
endmodule

// File: rtl/rom_load_ctrl.sv
// rom_load_ctrl: sequences core reset around HPS ioctl downloads and demuxes the byte stream
// Ports:
//   clk_sys, reset                     clock, asynchronous active-high reset
//   ioctl_download/index/wr/addr/dout  hps_io download interface
//   user_reset                         level reset request from menu or button
//   dn_addr/dn_data/dn_wr              registered ROM write port (1-cycle latency)
//   mod                                latched variant byte
//   sw0..sw2                           switch bytes 0..2 (bytes 3..7 kept internally)
//   core_reset                         reset to the game core
//   busy                               high while a ROM/mod download is in progress
//   load_err                           sticky out-of-range ROM write flag
//   checksum                           additive ROM checksum, tied to 0 unless
//                                      ROM_LOAD_CHECKSUM_EN is defined
module rom_load_ctrl
  import rom_load_pkg::*;
#(
  parameter int unsigned ROM_SIZE = ROM_SIZE_DEF,
  parameter int unsigned RST_CYCLES = RST_CYCLES_DEF,
  parameter logic [7:0] ROM_INDEX = ROM_IDX,
  parameter logic [7:0] MOD_INDEX = MOD_IDX,
  parameter logic [7:0] SW_INDEX = SW_IDX
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        user_reset,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic [7:0]  mod,
  output logic [7:0]  sw0,
  output logic [7:0]  sw1,
  output logic [7:0]  sw2,
  output logic        core_reset,
  output logic        busy,
  output logic        load_err,
  output logic [7:0]  checksum
);
  localparam logic [15:0] RELOAD = 16'(RST_CYCLES - 1);
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic dl_rise, dl_fall, start, load_entry;
  logic rom_wr, in_range, rom_ok, mod_wr, sw_wr;
  logic [15:0] dn_addr_q, dn_addr_d;
  logic [7:0] dn_data_q, dn_data_d, mod_q, mod_d;
  logic dn_wr_q, load_err_q, load_err_d, core_reset_q, busy_q;
  logic [7:0] sw_q [8];
  logic [7:0] sw_d [8];
  logic sw_unused;
  edge_det u_dl_edge (
    .clk    (clk_sys),
    .rst    (reset),
    .d_i    (ioctl_download),
    .rise_o (dl_rise),
    .fall_o (dl_fall)
  );
  // Only ROM and mod downloads take the core down; the index is sampled on the rising edge.
  assign start = dl_rise & (ioctl_index == ROM_INDEX | ioctl_index == MOD_INDEX);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      RUN:
        if (start) state_d = LOAD;
        else if (user_reset) begin
          state_d = HOLD;
          cnt_d = RELOAD;
        end
      LOAD:
        if (dl_fall) begin
          state_d = HOLD;
          cnt_d = RELOAD;
        end
      HOLD:
        if (start) state_d = LOAD;
        else if (user_reset) cnt_d = RELOAD;
        else if (cnt_q == 16'd0) state_d = RUN;
        else cnt_d = cnt_q - 16'd1;
      default: begin
        state_d = HOLD;
        cnt_d = RELOAD;
      end
    endcase
  end
  assign load_entry = state_q != LOAD && state_d == LOAD;
  assign rom_wr = ioctl_wr & ioctl_index == ROM_INDEX & state_q == LOAD;
  assign in_range = 32'(ioctl_addr) < ROM_SIZE;
  assign rom_ok = rom_wr & in_range;
  assign mod_wr = ioctl_wr & ioctl_index == MOD_INDEX & ioctl_addr == '0;
  assign sw_wr = ioctl_wr & ioctl_index == SW_INDEX & ioctl_addr[24:3] == '0;
  assign dn_addr_d = rom_ok ? ioctl_addr[15:0] : dn_addr_q;
  assign dn_data_d = rom_ok ? ioctl_dout : dn_data_q;
  assign load_err_d = load_entry ? 1'b0 : (rom_wr & ~in_range) ? 1'b1 : load_err_q;
  assign mod_d = mod_wr ? ioctl_dout : mod_q;
  always_comb begin
    sw_d = sw_q;
    if (sw_wr) sw_d[ioctl_addr[2:0]] = ioctl_dout;
  end
  // core_reset/busy are registered from the next state so the core never sees a decode glitch.
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      state_q <= HOLD;
      cnt_q <= RELOAD;
      core_reset_q <= 1'b1;
      busy_q <= 1'b0;
      dn_wr_q <= 1'b0;
      dn_addr_q <= '0;
      dn_data_q <= '0;
      load_err_q <= 1'b0;
      mod_q <= '0;
      sw_q <= '{default: SW_RESET_VAL};
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      core_reset_q <= state_d != RUN;
      busy_q <= state_d == LOAD;
      dn_wr_q <= rom_ok;
      dn_addr_q <= dn_addr_d;
      dn_data_q <= dn_data_d;
      load_err_q <= load_err_d;
      mod_q <= mod_d;
      sw_q <= sw_d;
    end
`ifdef ROM_LOAD_CHECKSUM_EN
  logic [7:0] chk_q, chk_d;
  assign chk_d = load_entry ? 8'h00 : rom_ok ? chk_q + ioctl_dout : chk_q;
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) chk_q <= 8'h00;
    else chk_q <= chk_d;
  assign checksum = chk_q;
`else
  assign checksum = 8'h00;
`endif
  // Switch bytes 3..7 are kept for future inputs but have no output yet.
  assign sw_unused = ^{sw_q[3], sw_q[4], sw_q[5], sw_q[6], sw_q[7]};
  assign dn_addr = dn_addr_q;
  assign dn_data = dn_data_q;
  assign dn_wr = dn_wr_q;
  assign mod = mod_q;
  assign sw0 = sw_q[0];
  assign sw1 = sw_q[1];
  assign sw2 = sw_q[2];
  assign core_reset = core_reset_q;
  assign busy = busy_q;
  assign load_err = load_err_q;
endmodule

// File: tb/tb_rom_load_ctrl.sv
// tb_rom_load_ctrl: directed/randomized self-checking bench for rom_load_ctrl
module tb_rom_load_ctrl;
  localparam int RST = 256;
  localparam int RSIZE = 16384;
  logic clk_sys = 1'b0, reset = 1'b1, ioctl_download = 1'b0, ioctl_wr = 1'b0, user_reset = 1'b0;
  logic [7:0] ioctl_index = 8'd0, ioctl_dout = 8'd0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [15:0] dn_addr;
  logic [7:0] dn_data, mod, sw0, sw1, sw2, checksum;
  logic dn_wr, core_reset, busy, load_err;
  int vectors = 0, miscompares = 0;
  logic [7:0] sw_m [8];
  logic [7:0] mod_m, csum_m;
  logic err_m, loading;

  rom_load_ctrl #(.ROM_SIZE(RSIZE), .RST_CYCLES(RST)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .user_reset(user_reset), .dn_addr(dn_addr),
    .dn_data(dn_data), .dn_wr(dn_wr), .mod(mod), .sw0(sw0), .sw1(sw1), .sw2(sw2),
    .core_reset(core_reset), .busy(busy), .load_err(load_err), .checksum(checksum)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [7:0] csum_exp();
`ifdef ROM_LOAD_CHECKSUM_EN
    return csum_m;
`else
    return 8'h00;
`endif
  endfunction

  task automatic check_banks(input string tag);
    check({tag, "_mod"}, mod, mod_m);
    check({tag, "_sw0"}, sw0, sw_m[0]);
    check({tag, "_sw1"}, sw1, sw_m[1]);
    check({tag, "_sw2"}, sw2, sw_m[2]);
  endtask

  task automatic wait_release(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (core_reset && n < 2000);
    check(tag, n, RST);
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    tick();
    if (idx == 8'd0 || idx == 8'd1) begin
      loading = 1'b1;
      csum_m = 8'h00;
      err_m = 1'b0;
    end
  endtask

  task automatic end_dl;
    ioctl_download = 1'b0;
    tick();
    loading = 1'b0;
  endtask

  task automatic wr(input logic [24:0] a, input logic [7:0] d);
    logic exp_wr;
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    exp_wr = loading && ioctl_index == 8'd0 && a < 25'(RSIZE);
    if (loading && ioctl_index == 8'd0 && !exp_wr) err_m = 1'b1;
    if (exp_wr) csum_m = csum_m + d;
    if (ioctl_index == 8'd1 && a == 25'd0) mod_m = d;
    if (ioctl_index == 8'd254 && a < 25'd8) sw_m[a[2:0]] = d;
    check("dn_wr", dn_wr, exp_wr);
    if (exp_wr) begin
      check("dn_addr", dn_addr, a[15:0]);
      check("dn_data", dn_data, d);
    end
    check("load_err", load_err, err_m);
    check_banks("wr");
    if (exp_wr) begin
      tick();
      check("dn_wr_pulse", dn_wr, 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) sw_m[i] = 8'hFF;
    mod_m = 8'h00;
    csum_m = 8'h00;
    err_m = 1'b0;
    loading = 1'b0;
    repeat (3) tick();
    check("rst_core_reset", core_reset, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_load_err", load_err, 1'b0);
    check("rst_dn_wr", dn_wr, 1'b0);
    check("rst_dn_addr", dn_addr, 16'h0000);
    check("rst_dn_data", dn_data, 8'h00);
    check("rst_checksum", checksum, 8'h00);
    check_banks("rst");
    reset = 1'b0;
    wait_release("powerup_hold");
    check("run_busy", busy, 1'b0);
    start_dl(8'd0);
    check("load_busy", busy, 1'b1);
    check("load_core_reset", core_reset, 1'b1);
    wr(25'd0, 8'h11);
    wr(25'd1, 8'h22);
    wr(25'd2, 8'h33);
    wr(25'd3, 8'h44);
    check("load_busy_end", busy, 1'b1);
    end_dl();
    check("hold_busy", busy, 1'b0);
    check("hold_core_reset", core_reset, 1'b1);
    check("checksum_aa", checksum, csum_exp());
    wait_release("load_release");
    start_dl(8'd0);
    for (int i = 0; i < 6; i++) wr(25'($urandom_range(RSIZE - 1, 0)), 8'($urandom));
    wr(25'h4000, 8'($urandom));
    wr(25'($urandom_range(32'h1FF_FFFF, RSIZE)), 8'($urandom));
    wr(25'($urandom_range(RSIZE - 1, 0)), 8'($urandom));
    end_dl();
    check("err_sticky", load_err, 1'b1);
    check("checksum_rand", checksum, csum_exp());
    repeat (5) tick();
    start_dl(8'd0);
    check("err_cleared", load_err, 1'b0);
    check("reload_busy", busy, 1'b1);
    user_reset = 1'b1;
    tick();
    user_reset = 1'b0;
    check("load_ignores_user_reset", busy, 1'b1);
    end_dl();
    wait_release("reload_release");
    ioctl_index = 8'd0;
    wr(25'd5, 8'h99);
    start_dl(8'd254);
    check("dip_core_reset", core_reset, 1'b0);
    check("dip_busy", busy, 1'b0);
    wr(25'd2, 8'h5A);
    check("dip_sw2", sw2, 8'h5A);
    wr(25'd9, 8'h77);
    wr(25'd0, 8'($urandom));
    wr(25'd1, 8'($urandom));
    end_dl();
    repeat (3) tick();
    check("dip_run", core_reset, 1'b0);
    start_dl(8'd7);
    check("other_idx_run", core_reset, 1'b0);
    end_dl();
    start_dl(8'd1);
    check("mod_busy", busy, 1'b1);
    wr(25'd0, 8'($urandom_range(255, 1)));
    wr(25'd1, 8'($urandom));
    end_dl();
    wait_release("mod_release");
    user_reset = 1'b1;
    tick();
    user_reset = 1'b0;
    check("ureset_hold", core_reset, 1'b1);
    repeat (99) tick();
    check("ureset_hold_99", core_reset, 1'b1);
    user_reset = 1'b1;
    tick();
    user_reset = 1'b0;
    wait_release("ureset_extend");
    check_banks("ureset");
    user_reset = 1'b1;
    tick();
    user_reset = 1'b0;
    repeat (10) tick();
    user_reset = 1'b1;
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    tick();
    user_reset = 1'b0;
    loading = 1'b1;
    csum_m = 8'h00;
    err_m = 1'b0;
    check("prio_busy", busy, 1'b1);
    check("prio_core_reset", core_reset, 1'b1);
    wr(25'($urandom_range(RSIZE - 1, 0)), 8'($urandom));
    wr(25'($urandom_range(RSIZE - 1, 0)), 8'($urandom));
    end_dl();
    check("prio_checksum", checksum, csum_exp());
    wait_release("prio_release");
    start_dl(8'd0);
    wr(25'd3, 8'($urandom));
    ioctl_addr = 25'd4;
    ioctl_dout = 8'hC3;
    ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
    check("inflight_dn_wr", dn_wr, 1'b1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    loading = 1'b0;
    #1;
    check("async_dn_wr", dn_wr, 1'b0);
    check("async_busy", busy, 1'b0);
    check("async_core_reset", core_reset, 1'b1);
    for (int i = 0; i < 8; i++) sw_m[i] = 8'hFF;
    mod_m = 8'h00;
    csum_m = 8'h00;
    err_m = 1'b0;
    tick();
    check_banks("midreset");
    check("midreset_checksum", checksum, 8'h00);
    check("midreset_dn_addr", dn_addr, 16'h0000);
    reset = 1'b0;
    wait_release("midreset_release");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rom_load_ctrl.md
Name: rom_load_ctrl

Overview:
- Sequences the arcade core around HPS ioctl downloads.
- Demultiplexes the ioctl byte stream into three destinations: the ROM loader port, the game-variant (mod) register and the 8-byte DIP/switch bank.
- Holds the core in reset while ROM/mod data is being written, then releases it after a fixed settle interval.
- Sits between hps_io and the pacman core in the emu top level, and replaces the ad-hoc mod/sw capture logic.

Parameters:
- ROM_SIZE, 65536: number of valid ROM bytes. Writes at or above this address are dropped.
- RST_CYCLES, 256: core-reset hold length in clk_sys cycles after a load ends or after a user reset. Legal range is 2..65535.
- ROM_INDEX, 0: ioctl_index value for ROM data.
- MOD_INDEX, 1: ioctl_index value for the variant byte.
- SW_INDEX, 254: ioctl_index value for the DIP/switch bank.

Ports:
- clk_sys  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- ioctl_download  in  1  download in progress.
- ioctl_index  in  8  download target selector.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- user_reset  in  1  level reset request (menu reset OR button).
- dn_addr  out  16  ROM write address.
- dn_data  out  8  ROM write data.
- dn_wr  out  1  ROM write strobe.
- mod  out  8  latched variant byte.
- sw0, sw1, sw2  out  8 each  switch bytes 0..2 (in0 mask, in1 mask, dipsw).
- core_reset  out  1  reset to the game core.
- busy  out  1  high while in LOAD.
- load_err  out  1  sticky out-of-range flag.
- checksum  out  8  ROM additive checksum (optional feature).

Behaviour:
- Reset values:
  - State is HOLD with the hold counter set to RST_CYCLES-1.
  - core_reset=1, busy=0, load_err=0, dn_wr=0, dn_addr=0, dn_data=0, mod=0, checksum=0.
  - Switch bank: all 8 bytes = 8'hFF.
- State machine (three states: RUN, LOAD, HOLD):
  - RUN: core_reset=0.
    - Rising edge of ioctl_download with index ROM_INDEX or MOD_INDEX -> LOAD.
    - Otherwise user_reset=1 -> HOLD with the counter reloaded.
  - LOAD: core_reset=1, busy=1.
    - Falling edge of ioctl_download -> HOLD with the counter reloaded.
    - user_reset is ignored in this state.
  - HOLD: core_reset=1.
    - Counter decrements by one each cycle; at 0 -> RUN.
    - user_reset=1 reloads the counter.
    - A qualifying download start -> LOAD (download start takes priority over user_reset).
- Edge detection: ioctl_download is registered once and edges are taken against that registered copy. Index is sampled on the edge.
- Downloads with index SW_INDEX, or any other index, do not change state and do not reset the core.
- ROM path (ioctl_wr & index==ROM_INDEX & in LOAD):
  - Latency is 1 cycle: dn_wr, dn_addr=ioctl_addr[15:0] and dn_data are registered.
  - dn_wr is a single-cycle pulse.
  - If ioctl_addr >= ROM_SIZE, no dn_wr is issued and load_err is set.
  - ROM writes arriving outside LOAD are dropped silently.
- load_err is cleared on each entry to LOAD.
- Mod path: ioctl_wr & index==MOD_INDEX & ioctl_addr==0 -> mod<=ioctl_dout. Higher addresses are ignored.
- Switch path: ioctl_wr & index==SW_INDEX & ioctl_addr[24:3]==0 -> bank[ioctl_addr[2:0]]<=ioctl_dout.
  - Accepted in any state.
  - Outputs are registered: 1-cycle latency.
  - Bytes 3..7 are stored internally but not exported.
- Reset asserted mid-load: everything returns to reset values. The in-flight dn_wr is lost; the host must re-download.
- mod and the switch bank survive user_reset. Only the reset port clears them.

Optional Feature:
- Macro: ROM_LOAD_CHECKSUM_EN.
- When defined:
  - checksum clears on LOAD entry.
  - Each accepted ROM byte is added to it modulo 256, in the same cycle that dn_wr is registered.
  - The value holds until the next LOAD.
- When undefined: checksum is tied to 8'h00 and no adder is synthesised. The port list is identical in both builds.

Decomposition:
- Shared package rom_load_pkg holds:
  - the state enum (RUN, LOAD, HOLD);
  - the index localparams;
  - the SW_RESET_VAL constant (8'hFF).
- One natural sub-module, edge_det: a registered rise/fall detector, instanced for ioctl_download.

Test Plan:
- Power-up: pulse reset, hold idle -> core_reset=1 for exactly 256 cycles after reset release, then 0. sw0..sw2=FF, mod=00.
- ROM load, index 0, bytes at addresses 0..3 = 11,22,33,44:
  - busy=1 and core_reset=1 throughout.
  - Four dn_wr pulses, each 1 cycle after its ioctl_wr, with matching dn_addr and dn_data.
  - checksum=AA when the macro is defined.
  - Release 256 cycles after ioctl_download falls.
- Out-of-range write with ROM_SIZE=16384, address 0x4000 -> no dn_wr, load_err=1. A subsequent new load clears load_err.
- DIP download during RUN, index 254, address 2 = 0x5A, address 9 = 0x77 -> sw2=5A one cycle later. Address 9 is ignored. core_reset stays 0.
- user_reset pulse in RUN, re-asserted at cycle 100 of HOLD -> hold extends to 100+256 cycles. mod and sw are unchanged.
- user_reset high in the same cycle as a ROM download start during HOLD -> state goes to LOAD and busy=1.
